bus_arbiter: RTL and testbench

Round-robin arbiter and master-side multiplexer for the shared system bus. It owns the shared bus between up to four bus masters, each an instance of the CPU bus interface (instruction-fetch port, data port, DMA, debug). It grants ownership through the active-low req_/grnt_ handshake, holds the grant until the owner releases its request, and steers the owner's address/control/write-data onto the shared bus toward the slaves.

---
 rtl/bus_arbiter_pkg.sv | 33 +++
 rtl/bus_arb_rr_pick.sv | 32 +++
 rtl/bus_arbiter.sv | 130 +++++++++++++
 tb/tb_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the system-bus arbiter: owner index type,
// arbiter state encoding, master indices and the bus-level polarity constants.
package bus_arbiter_pkg;

  localparam int WORD_W  = 32;
  localparam int MST_CNT = 4;

  // Owner index, one of the four masters.
  typedef logic [1:0] bus_owner_t;

  // IDLE: no grant outstanding. OWNED: exactly one grant held low.
  typedef enum logic {
    ARB_STATE_IDLE  = 1'b0,
    ARB_STATE_OWNED = 1'b1
  } arb_state_t;

  localparam bus_owner_t BUS_MASTER_0 = 2'd0;  // instruction fetch
  localparam bus_owner_t BUS_MASTER_1 = 2'd1;  // data port
  localparam bus_owner_t BUS_MASTER_2 = 2'd2;  // DMA
  localparam bus_owner_t BUS_MASTER_3 = 2'd3;  // debug

  // Bus-level encodings: rw high means read, strobes/grants are active-low.
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // One-hot (active-high) mask selecting a single master.
  function automatic logic [MST_CNT-1:0] owner_onehot(input bus_owner_t o);
    return 4'b0001 << o;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational 4-way round-robin picker. Scans start, start+1, ... modulo 4
// over the active-high request vector with excluded masters masked off, and
// reports the first hit.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [MST_CNT-1:0] req,
  input  bus_owner_t         start,
  input  logic [MST_CNT-1:0] excl,
  output logic               found,
  output bus_owner_t         winner
);

  logic [MST_CNT-1:0] cand;
  bus_owner_t         idx;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    cand   = req & ~excl;
    found  = 1'b0;
    winner = start;
    idx    = start;
    for (int k = MST_CNT - 1; k >= 0; k--) begin
      idx = start + bus_owner_t'(k);
      if (cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner FSM and master-side multiplexer for the shared system bus.
// Grants are registered and held until the owner raises its request; a release
// hands over directly to the next requester without an idle cycle.
//
// Handshake: a master requests by driving m_req_[i] low and owns the bus for
// every cycle m_grnt_[i] is low; it gives the bus back by driving m_req_[i]
// high, which drops the grant after the next rising edge. Owners drive their
// strobe only while granted; strobes of non-owners never reach the bus.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WORD_W = bus_arbiter_pkg::WORD_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MST_CNT-1:0]        m_req_,
  output logic [MST_CNT-1:0]        m_grnt_,
  input  logic [MST_CNT*WORD_W-1:0] m_addr,
  input  logic [MST_CNT-1:0]        m_as_,
  input  logic [MST_CNT-1:0]        m_rw,
  input  logic [MST_CNT*WORD_W-1:0] m_wr_data,
  output logic [WORD_W-1:0]         s_addr,
  output logic                      s_as_,
  output logic                      s_rw,
  output logic [WORD_W-1:0]         s_wr_data,
  output bus_owner_t                arb_owner,
  output logic                      arb_busy,
  output arb_state_t                dbg_state
);

  arb_state_t state_q, state_d;
  bus_owner_t owner_q, owner_d;
  bus_owner_t nxt_q, nxt_d;

  logic [MST_CNT-1:0] pick_req;
  bus_owner_t         pick_start;
  logic [MST_CNT-1:0] pick_excl;
  logic               pick_found;
  bus_owner_t         pick_winner;
  logic               owner_release;

  // The owner's request going high is the only way a tenure ends.
  assign owner_release = (state_q == ARB_STATE_OWNED) && (m_req_[owner_q] == DISABLE_);

  // Idle scans from the saved pointer; a handover scans past the releasing owner.
  always_comb begin
    pick_req   = ~m_req_;
    pick_start = nxt_q;
    pick_excl  = '0;
    if (state_q == ARB_STATE_OWNED) begin
      pick_start = owner_q + 2'd1;
      pick_excl  = owner_onehot(owner_q);
    end
  end

  bus_arb_rr_pick u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .excl   (pick_excl),
    .found  (pick_found),
    .winner (pick_winner)
  );

  // Owner FSM state, owner index and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_STATE_IDLE;
      owner_q <= BUS_MASTER_0;
      nxt_q   <= BUS_MASTER_0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      nxt_q   <= nxt_d;
    end
  end

  // Next-state: grant from idle, hold while requested, hand over or go idle on release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    nxt_d   = nxt_q;
    case (state_q)
      ARB_STATE_IDLE: begin
        if (pick_found) begin
          state_d = ARB_STATE_OWNED;
          owner_d = pick_winner;
        end
      end
      ARB_STATE_OWNED: begin
        if (owner_release) begin
          nxt_d = owner_q + 2'd1;
          if (pick_found) begin
            owner_d = pick_winner;
          end else begin
            state_d = ARB_STATE_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_STATE_IDLE;
      end
    endcase
  end

  // Grant and status outputs decode straight from registered state.
  always_comb begin
    arb_busy  = (state_q == ARB_STATE_OWNED);
    arb_owner = owner_q;
    dbg_state = state_q;
    m_grnt_   = {MST_CNT{DISABLE_}};
    if (arb_busy) begin
      m_grnt_ = ~owner_onehot(owner_q);
    end
  end

  // Shared-bus mux: the owner's signals, or a quiet read-idle bus.
  always_comb begin
    s_addr    = '0;
    s_as_     = DISABLE_;
    s_rw      = READ;
    s_wr_data = '0;
    if (state_q == ARB_STATE_OWNED) begin
      s_addr    = m_addr[owner_q*WORD_W +: WORD_W];
      s_as_     = m_as_[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data = m_wr_data[owner_q*WORD_W +: WORD_W];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a spec-level arbitration model predicts
// each cycle's grant/owner, expectations queue up as stimulus is driven and are
// popped and compared one edge later; directed scenarios add fixed checks.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int W = 32;

  logic              clk;
  logic              reset;
  logic [3:0]        m_req_;
  logic [3:0]        m_grnt_;
  logic [4*W-1:0]    m_addr;
  logic [3:0]        m_as_;
  logic [3:0]        m_rw;
  logic [4*W-1:0]    m_wr_data;
  logic [W-1:0]      s_addr;
  logic              s_as_;
  logic              s_rw;
  logic [W-1:0]      s_wr_data;
  bus_owner_t        arb_owner;
  logic              arb_busy;
  arb_state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  // expected {busy, owner[1:0], grnt_[3:0]}
  logic [6:0] exp_q[$];

  // reference model state
  logic       mdl_busy;
  logic [1:0] mdl_own;
  logic [1:0] mdl_nxt;

  bus_arbiter #(.WORD_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req_    (m_req_),
    .m_grnt_   (m_grnt_),
    .m_addr    (m_addr),
    .m_as_     (m_as_),
    .m_rw      (m_rw),
    .m_wr_data (m_wr_data),
    .s_addr    (s_addr),
    .s_as_     (s_as_),
    .s_rw      (s_rw),
    .s_wr_data (s_wr_data),
    .arb_owner (arb_owner),
    .arb_busy  (arb_busy),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_busy = 1'b0;
    mdl_own  = 2'd0;
    mdl_nxt  = 2'd0;
  endtask

  // Arbitration behaviour for one edge given the sampled request vector.
  task automatic model_step(input logic [3:0] rq_n);
    logic [3:0] req;
    logic       found;
    logic [1:0] idx, win, start;
    req   = ~rq_n;
    found = 1'b0;
    win   = 2'd0;
    if (!mdl_busy) begin
      for (int k = 0; k < 4; k++) begin
        idx = mdl_nxt + 2'(k);
        if (!found && req[idx]) begin found = 1'b1; win = idx; end
      end
      if (found) begin mdl_busy = 1'b1; mdl_own = win; end
    end else if (!req[mdl_own]) begin
      start   = mdl_own + 2'd1;
      mdl_nxt = start;
      for (int k = 0; k < 3; k++) begin
        idx = start + 2'(k);
        if (!found && req[idx]) begin found = 1'b1; win = idx; end
      end
      if (found) mdl_own = win;
      else       mdl_busy = 1'b0;
    end
  endtask

  function automatic logic [3:0] mdl_grnt();
    logic [3:0] g;
    g = 4'b1111;
    if (mdl_busy) g[mdl_own] = 1'b0;
    return g;
  endfunction

  // Shared-bus values expected from the model owner and the current inputs.
  task automatic check_bus();
    if (mdl_busy) begin
      check("s_addr", s_addr, m_addr[mdl_own*W +: W]);
      check("s_as_", s_as_, m_as_[mdl_own]);
      check("s_rw", s_rw, m_rw[mdl_own]);
      check("s_wr_data", s_wr_data, m_wr_data[mdl_own*W +: W]);
    end else begin
      check("s_addr_idle", s_addr, 0);
      check("s_as_idle", s_as_, 1);
      check("s_rw_idle", s_rw, 1);
      check("s_wr_data_idle", s_wr_data, 0);
    end
  endtask

  // Driver: apply a request vector for one edge, scoreboard the result.
  task automatic drive_cycle(input logic [3:0] rq);
    logic [6:0] e;
    m_req_ = rq;
    model_step(rq);
    exp_q.push_back({mdl_busy, mdl_own, mdl_grnt()});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("grnt", m_grnt_, e[3:0]);
      check("busy", arb_busy, e[6]);
      check("state", dbg_state, e[6]);
      if (e[6]) check("owner", arb_owner, e[5:4]);
    end
    check_bus();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_grnt", m_grnt_, 4'b1111);
    check("rst_busy", arb_busy, 0);
    check("rst_s_as_", s_as_, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic randomize_masters();
    for (int i = 0; i < 4; i++) begin
      m_addr[i*W +: W]    = $urandom;
      m_wr_data[i*W +: W] = $urandom;
    end
    m_as_ = 4'($urandom_range(0, 15));
    m_rw  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic [1:0] seq[$];
    logic       prev_busy;
    logic [1:0] prev_own;
    int         cnt;
    logic [3:0] rq;

    reset  = 1'b0;
    m_req_ = 4'b0000;
    randomize_masters();
    model_reset();

    // 1: reset held with all masters requesting
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_grnt", m_grnt_, 4'b1111);
    check("rst_hold_s_as_", s_as_, 1);
    check("rst_hold_s_addr", s_addr, 0);
    check("rst_hold_owner", arb_owner, 0);
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(4'b0000);
    check("first_grant", m_grnt_, 4'b1110);
    check("first_owner", arb_owner, 0);
    drive_cycle(4'b1111);

    // 2: master 2 alone, write transaction
    m_addr[2*W +: W]    = 32'h2800_0010;
    m_wr_data[2*W +: W] = 32'hDEAD_BEEF;
    m_as_[2]            = 1'b0;
    m_rw[2]             = 1'b0;
    drive_cycle(4'b1011);
    check("m2_grant", m_grnt_, 4'b1011);
    check("m2_s_addr", s_addr, 32'h2800_0010);
    check("m2_s_wr_data", s_wr_data, 32'hDEAD_BEEF);
    check("m2_s_rw", s_rw, 0);
    check("m2_s_as_", s_as_, 0);
    drive_cycle(4'b1111);
    check("m2_release", m_grnt_, 4'b1111);
    check("m2_release_as", s_as_, 1);

    // 3: all four continuously, three-cycle tenures
    apply_reset();
    prev_busy = 1'b0;
    prev_own  = 2'd0;
    cnt       = 0;
    for (int c = 0; c < 16; c++) begin
      rq = 4'b0000;
      if (mdl_busy && cnt == 3) rq[mdl_own] = 1'b1;
      drive_cycle(rq);
      if (mdl_busy && (!prev_busy || mdl_own != prev_own)) begin
        seq.push_back(mdl_own);
        cnt = 1;
      end else if (mdl_busy) begin
        cnt++;
      end
      if (c > 0) check("rr_no_idle", arb_busy, 1);
      prev_busy = mdl_busy;
      prev_own  = mdl_own;
    end
    check("rr_seq_len_ok", seq.size() >= 5, 1);
    if (seq.size() >= 5) begin
      check("rr_seq0", seq[0], 0);
      check("rr_seq1", seq[1], 1);
      check("rr_seq2", seq[2], 2);
      check("rr_seq3", seq[3], 3);
      check("rr_seq4", seq[4], 0);
    end

    // 4: owner 1 releases and only master 1 comes back
    apply_reset();
    drive_cycle(4'b1101);
    check("m1_grant", m_grnt_, 4'b1101);
    drive_cycle(4'b1101);
    drive_cycle(4'b1111);
    check("m1_idle", arb_busy, 0);
    drive_cycle(4'b1101);
    check("m1_regrant", m_grnt_, 4'b1101);

    // 5: master 3 holds 50 cycles against 0 and 1
    drive_cycle(4'b1111);
    drive_cycle(4'b0111);
    check("m3_grant", m_grnt_, 4'b0111);
    for (int c = 0; c < 50; c++) begin
      drive_cycle(4'b0100);
      check("m3_hold", arb_owner, 3);
    end
    drive_cycle(4'b1100);
    check("m3_wrap_to_0", m_grnt_, 4'b1110);

    // 6: async reset in the middle of master 2's tenure
    drive_cycle(4'b1011);
    check("m2b_grant", m_grnt_, 4'b1011);
    drive_cycle(4'b1011);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("async_grnt", m_grnt_, 4'b1111);
    check("async_busy", arb_busy, 0);
    check("async_s_as_", s_as_, 1);
    check("async_s_addr", s_addr, 0);
    check("async_s_wr_data", s_wr_data, 0);
    check("async_s_rw", s_rw, 1);
    @(negedge clk);
    reset = 1'b1;
    drive_cycle(4'b1010);
    check("post_rst_scan0", m_grnt_, 4'b1110);

    // random traffic, model-checked every cycle
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 7) == 0) randomize_masters();
      rq = 4'($urandom_range(0, 15));
      if (mdl_busy && $urandom_range(0, 3) != 0) rq[mdl_own] = 1'b0;
      drive_cycle(rq);
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
